// File: rtl/spi_slave_if.sv
// Bus bundle between the SPI responder and its surroundings: the board-level
// SPI pins plus the word-level TX buffer / RX result handshake.
interface spi_slave_if #(
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              busy;

    // The responder itself.
    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

    // Whoever drives the pins and feeds the TX buffer.
    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
endinterface

// File: rtl/spi_slave.sv
// Mode-0, MSB-first SPI responder. The SPI pins are oversampled in the clk
// domain; detected sclk edges drive shift registers for both directions and
// a one-entry TX buffer supplies the words that go out on miso.
module spi_slave #(
    parameter int DATA_W = 8
) (
    input  logic     clk,
    input  logic     rst,
    spi_slave_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [2:0]        r_sclk_sync;
    logic [2:0]        r_cs_sync;
    logic [1:0]        r_mosi_sync;
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_rx_shift;
    logic [DATA_W-1:0] r_tx_shift;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_miso_oe;
    logic [DATA_W-1:0] r_buf;
    logic              r_buf_full;
    logic              r_underrun;

    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_cs_rise;
    logic              w_cs_fall;
    logic              w_mosi;
    logic              w_abort;
    logic              w_load;
    logic              w_accept;
    logic [DATA_W-1:0] w_load_word;
    logic [DATA_W-1:0] w_rx_next;

    // Pin synchronizers; sclk and cs_n carry a third stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage take the previous
            // stage's old value, so this really is a chain of flops.
            r_sclk_sync <= {r_sclk_sync[1:0], bus.sclk};
            r_cs_sync   <= {r_cs_sync[1:0], bus.cs_n};
            r_mosi_sync <= {r_mosi_sync[0], bus.mosi};
        end
    end

    // mosi is taken from the same depth as the sclk edge detector input, so
    // the bit seen at a detected rise is the one the master set up for it.
    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_mosi      = r_mosi_sync[1];

    assign w_accept    = bus.tx_valid & ~r_buf_full;
    assign w_load_word = r_buf_full ? r_buf : '0;
    assign w_rx_next   = {r_rx_shift[DATA_W-2:0], w_mosi};

    // Decide abort and TX-register load; cs_n rise outranks everything else.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch
        // is inferred.
        w_abort = 1'b0;
        w_load  = 1'b0;
        if (w_cs_rise && r_state != S_IDLE) begin
            w_abort = 1'b1;
        end else if (r_state == S_IDLE && w_cs_fall) begin
            w_load = 1'b1;
        end else if (r_state == S_DONE && w_sclk_fall && !w_cs_fall) begin
            w_load = 1'b1;
        end
    end

    // One-entry TX buffer: an accept into an empty buffer survives a
    // same-cycle load, which only ever takes the previously stored word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data word is reset as well; it is a single register,
            // not a memory array, and a known value keeps miso clean.
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_load & ~r_buf_full;
            if (w_accept) begin
                r_buf      <= bus.tx_data;
                r_buf_full <= 1'b1;
            end else if (w_load) begin
                r_buf_full <= 1'b0;
            end
        end
    end

    // Frame sequencer: shifts on detected sclk edges, reports whole words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_miso_oe  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_abort) begin
                r_state    <= S_IDLE;
                r_bit_cnt  <= '0;
                r_rx_shift <= '0;
                r_tx_shift <= '0;
                r_miso_oe  <= 1'b0;
            end else if (w_load) begin
                r_tx_shift <= w_load_word;
                r_state    <= S_SHIFT;
                r_miso_oe  <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_bit_cnt <= '0;
                        r_miso_oe <= 1'b0;
                    end
                    S_SHIFT: begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= w_rx_next;
                            if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                                r_rx_data  <= w_rx_next;
                                r_rx_valid <= 1'b1;
                                r_bit_cnt  <= '0;
                                r_state    <= S_DONE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end else if (w_sclk_fall) begin
                            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                    S_DONE: begin
                        // Waiting for the closing sclk fall (handled as a load)
                        // or for cs_n to rise.
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_bit_cnt <= '0;
                        r_miso_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.miso        = r_miso_oe & r_tx_shift[DATA_W-1];
    assign bus.miso_oe     = r_miso_oe;
    assign bus.tx_ready    = ~r_buf_full;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.tx_underrun = r_underrun;
    assign bus.busy        = (r_state != S_IDLE);
endmodule
